// File: rtl/vram_scroll_engine.sv
// rtl/vram_scroll_engine.sv - VRAM fill/scroll sequencer arbitrating RAM port A with the host; optional ABORT input under VRAM_SCROLL_ABORT_EN
module vram_scroll_engine #(
    parameter int WORDS     = 1200,
    parameter int ROW_WORDS = 40,
    parameter int ROWS      = 30,
    parameter int AW        = 11
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          HOST_READ,
    input  logic          HOST_WRITE,
    input  logic [AW-1:0] HOST_ADDR,
    input  logic [3:0]    HOST_BYTE_EN,
    input  logic [31:0]   HOST_WRITEDATA,
    output logic          HOST_WAIT,
    output logic [31:0]   HOST_READDATA,
    input  logic          CMD_VALID,
    output logic          CMD_READY,
    input  logic          CMD_OP,
    input  logic [4:0]    CMD_ROWS,
    input  logic [31:0]   CMD_FILL,
`ifdef VRAM_SCROLL_ABORT_EN
    input  logic          ABORT,
`endif
    output logic          BUSY,
    output logic          DONE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [3:0]    MEM_BYTE_EN,
    output logic [31:0]   MEM_WDATA,
    output logic          MEM_WREN,
    output logic          MEM_RDEN,
    input  logic [31:0]   MEM_RDATA
);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_SCR_RD, S_SCR_WR, S_FIN} state_t;

    localparam logic [AW-1:0] LAST_WORD = AW'(WORDS - 1);
    localparam logic [4:0]    ROWS_MAX  = 5'(ROWS);

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] move_q, move_d;
    logic [4:0]    rows_q, rows_d;
    logic [31:0]   fill_q, fill_d;
    logic [31:0]   hold_q, hold_d;
    logic          rd_pend_q, rd_pend_d;
    logic          last_host_q, last_host_d;

    logic          eng_req, host_req, host_gnt, eng_gnt;
    logic [4:0]    rows_clamp;
    logic [AW-1:0] src_offset, eng_addr;
    logic [31:0]   eng_wdata;
    logic          eng_wren, eng_rden;

    // Port A arbitration: sole requester wins, contention alternates on the last grant
    always_comb begin
        eng_req  = (state_q == S_FILL) || (state_q == S_SCR_RD) || (state_q == S_SCR_WR);
        host_req = HOST_READ | HOST_WRITE;
        host_gnt = host_req && (!eng_req || !last_host_q);
        eng_gnt  = eng_req && !host_gnt;
    end

    // Engine access for the current state; a scroll write right after its read bypasses the hold register
    always_comb begin
        src_offset = AW'(int'(rows_q) * ROW_WORDS);
        eng_addr   = ptr_q;
        eng_wdata  = fill_q;
        eng_wren   = 1'b0;
        eng_rden   = 1'b0;
        case (state_q)
            S_FILL: eng_wren = 1'b1;
            S_SCR_RD: begin
                eng_addr = ptr_q + src_offset;
                eng_rden = 1'b1;
            end
            S_SCR_WR: begin
                eng_wdata = rd_pend_q ? MEM_RDATA : hold_q;
                eng_wren  = 1'b1;
            end
            default: ;
        endcase
    end

    // Drive port A from whichever requester holds the grant; status outputs
    always_comb begin
        MEM_ADDR    = eng_addr;
        MEM_BYTE_EN = 4'hF;
        MEM_WDATA   = eng_wdata;
        MEM_WREN    = 1'b0;
        MEM_RDEN    = 1'b0;
        if (host_gnt) begin
            MEM_ADDR    = HOST_ADDR;
            MEM_BYTE_EN = HOST_BYTE_EN;
            MEM_WDATA   = HOST_WRITEDATA;
            MEM_WREN    = HOST_WRITE;
            MEM_RDEN    = HOST_READ & ~HOST_WRITE;
        end else if (eng_gnt) begin
            MEM_WREN = eng_wren;
            MEM_RDEN = eng_rden;
        end
        HOST_WAIT     = host_req & ~host_gnt;
        HOST_READDATA = MEM_RDATA;
        CMD_READY     = (state_q == S_IDLE);
        BUSY          = (state_q != S_IDLE);
        DONE          = (state_q == S_FIN);
    end

    // Command sequencing; engine states only advance when the engine holds the port
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rows_d      = rows_q;
        move_d      = move_q;
        fill_d      = fill_q;
        hold_d      = rd_pend_q ? MEM_RDATA : hold_q;
        rd_pend_d   = eng_gnt && (state_q == S_SCR_RD);
        last_host_d = host_gnt ? 1'b1 : (eng_gnt ? 1'b0 : last_host_q);
        rows_clamp  = (CMD_ROWS > ROWS_MAX) ? ROWS_MAX : CMD_ROWS;
        case (state_q)
            S_IDLE: begin
                if (CMD_VALID) begin
                    fill_d = CMD_FILL;
                    rows_d = rows_clamp;
                    move_d = AW'((ROWS - int'(rows_clamp)) * ROW_WORDS);
                    ptr_d  = '0;
                    if (!CMD_OP || rows_clamp == ROWS_MAX) begin
                        state_d = S_FILL;
                    end else if (rows_clamp == 5'd0) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_SCR_RD;
                    end
                end
            end
            S_SCR_RD: begin
                if (eng_gnt) state_d = S_SCR_WR;
            end
            S_SCR_WR: begin
                if (eng_gnt) begin
                    ptr_d   = ptr_q + AW'(1);
                    state_d = ((ptr_q + AW'(1)) == move_q) ? S_FILL : S_SCR_RD;
                end
            end
            S_FILL: begin
                if (eng_gnt) begin
                    ptr_d = ptr_q + AW'(1);
                    if (ptr_q == LAST_WORD) state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef VRAM_SCROLL_ABORT_EN
        // The access granted this cycle still completes; the command ends next cycle
        if (ABORT && eng_req) state_d = S_FIN;
`endif
    end

    // State and datapath registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            move_q      <= '0;
            rows_q      <= '0;
            fill_q      <= '0;
            hold_q      <= '0;
            rd_pend_q   <= 1'b0;
            last_host_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            move_q      <= move_d;
            rows_q      <= rows_d;
            fill_q      <= fill_d;
            hold_q      <= hold_d;
            rd_pend_q   <= rd_pend_d;
            last_host_q <= last_host_d;
        end
    end

endmodule
